shift_add_multiplier: RTL and testbench

Sequential 5x5-bit unsigned multiplier built directly on top of the five-bit ripple adder. It is the first clocked consumer of `fiveBitAdder`: each cycle it feeds the adder the partial product and multiplicand, then registers and shifts the adder's sum and carry. It produces a 10-bit product after a fixed 5-iteration sequence under a start/busy/done handshake.

---
 rtl/mult_pkg.sv | 13 +
 rtl/fiveBitAdder.sv | 21 ++
 rtl/shift_add_multiplier.sv | 94 +++++++++
 tb/tb_shift_add_multiplier.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared widths, FSM encoding and iteration bound for the shift-add multiplier.
package mult_pkg;
  localparam int N_BITS = 5;
  localparam int P_BITS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] ITER_LAST = 3'd4;
endpackage

// File: rtl/fiveBitAdder.sv
// Five-bit combinational ripple-carry adder.
module fiveBitAdder
  import mult_pkg::*;
(
  output logic [N_BITS-1:0] sum,
  output logic              carry_out,
  input  logic [N_BITS-1:0] a,
  input  logic [N_BITS-1:0] b,
  input  logic              carry_in
);
  logic [N_BITS:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < N_BITS; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign carry_out = c[N_BITS];
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 5x5 unsigned multiplier: one add-and-shift per cycle through
// the ripple adder, start/busy/done handshake, registered 10-bit product.
module shift_add_multiplier
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_BITS-1:0] multiplicand,
  input  logic [N_BITS-1:0] multiplier,
  output logic [P_BITS-1:0] product,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [N_BITS-1:0] acc_q, acc_d;
  logic [N_BITS-1:0] q_q, q_d;
  logic [N_BITS-1:0] m_q, m_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [P_BITS-1:0] product_q, product_d;

  logic [N_BITS-1:0] add_b;
  logic [N_BITS-1:0] add_s;
  logic              add_c;
  logic [P_BITS-1:0] shifted;

  // Partial-product add: acc + (q[0] ? m : 0); carry kept as the new acc MSB.
  assign add_b = q_q[0] ? m_q : '0;

  fiveBitAdder u_add (
    .sum       (add_s),
    .carry_out (add_c),
    .a         (acc_q),
    .b         (add_b),
    .carry_in  (1'b0)
  );

  assign shifted = {add_c, add_s, q_q[N_BITS-1:1]};

  // Next-state: operand capture on accepted start, add/shift iterations in CALC.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        {acc_d, q_d} = shifted;
        cnt_d        = cnt_q + 3'd1;
        if (cnt_q == ITER_LAST) begin
          product_d = shifted;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any multiply in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign busy    = (state_q == CALC);
  assign done    = (state_q == DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] multiplicand = '0;
  logic [4:0] multiplier = '0;
  logic [9:0] product;
  logic       busy, done;

  shift_add_multiplier dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int at; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int held = 0;     // product value that must be held between completions
  int busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy && done) chk("busy_done_overlap", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", int'(product), e.p);
          chk("done_latency", cyc - e.at, 5);
          held = e.p;
        end
        chk("busy_cycles", busy_run, 5);
        busy_run = 0;
      end else begin
        chk("product_hold", int'(product), held);
        if (busy) busy_run++;
        else if (busy_run != 0) begin
          chk("busy_without_done", busy_run, 0);
          busy_run = 0;
        end
      end
    end
  end

  task automatic push(input int p, input int at);
    exp_t e;
    e.p = p; e.at = at;
    sb.push_back(e);
  endtask

  // Single start pulse; waits until the machine is back in IDLE.
  task automatic issue(input logic [4:0] a, input logic [4:0] b, input int p);
    @(negedge clk);
    multiplicand = a; multiplier = b; start = 1'b1;
    push(p, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  initial begin
    #1;
    chk("reset_product", int'(product), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    issue(5'd21, 5'd10, 210);
    issue(5'd31, 5'd31, 961);
    issue(5'd0,  5'd31, 0);
    issue(5'd31, 5'd0,  0);

    // Back-to-back with start held: 1x31 then 6x17, six cycles apart.
    @(negedge clk);
    multiplicand = 5'd1; multiplier = 5'd31; start = 1'b1;
    push(31, cyc + 1);
    push(102, cyc + 7);
    @(negedge clk);
    multiplicand = 5'b00110; multiplier = 5'b10001;
    repeat (6) @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);

    // Start re-pulsed during CALC with new operands must be ignored.
    @(negedge clk);
    multiplicand = 5'd21; multiplier = 5'd10; start = 1'b1;
    push(210, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    multiplicand = 5'd7; multiplier = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset during the 3rd CALC cycle.
    @(negedge clk);
    multiplicand = 5'd9; multiplier = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    held = 0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_product", int'(product), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    issue(5'd3, 5'd5, 15);

    // Operands scrambled every cycle after the accepting edge.
    @(negedge clk);
    multiplicand = 5'd21; multiplier = 5'd10; start = 1'b1;
    push(210, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      multiplicand = 5'($urandom);
      multiplier   = 5'($urandom);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    chk("pending_results", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
